// File: rtl/lms_avmm_cmd_bridge.sv
// lms_avmm_cmd_bridge
//   Pops command words from a show-ahead input FIFO, runs one Avalon-MM read or
//   write per command, and pushes response words into an output FIFO. A per-phase
//   timeout recovers from a stuck slave and is tallied in a saturating counter.
// Ports
//   clk_clk, reset_reset_n     clock, asynchronous active-low reset
//   soft_clr                   synchronous abort/clear (tmo_cnt is kept)
//   if_d/if_rdempty/if_rd      input FIFO (show-ahead data, empty, read strobe)
//   of_d/of_wr/of_wrfull       output FIFO (response word, write strobe, full)
//   avm_*                      Avalon-MM master
//   busy                       FSM is not idle
//   tmo_cnt                    saturating timeout count
// Command word: [CMD_W-1]=write, [ADDR_W+DATA_W-1:DATA_W]=address, [DATA_W-1:0]=wdata
// Response word: [CMD_W-1]=timeout, [CMD_W-2]=write ack, address field, read data
module lms_avmm_cmd_bridge #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CMD_W   = 32,
  parameter int unsigned TMO_CYC = 255,
  parameter int unsigned WR_ACK  = 0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              soft_clr,
  input  logic [CMD_W-1:0]  if_d,
  input  logic              if_rdempty,
  output logic              if_rd,
  output logic [CMD_W-1:0]  of_d,
  output logic              of_wr,
  input  logic              of_wrfull,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic [7:0]        tmo_cnt
);

  localparam int unsigned TMR_W = 16;
  localparam int unsigned CNT_W = 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_CYC - 1);

  // Elaboration-time parameter sanity
  if (ADDR_W + DATA_W + 1 > CMD_W) begin : g_bad_cmd_w
    $error("lms_avmm_cmd_bridge: CMD_W too small for ADDR_W+DATA_W+1");
  end
  if (TMO_CYC == 0 || TMO_CYC > 65535) begin : g_bad_tmo
    $error("lms_avmm_cmd_bridge: TMO_CYC must be 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMD     = 2'd1,
    S_WAIT_RD = 2'd2,
    S_RSP     = 2'd3
  } state_e;

  state_e             state_q,     state_d;
  logic [TMR_W-1:0]   timer_q,     timer_d;
  logic [CNT_W-1:0]   tmo_cnt_q,   tmo_cnt_d;
  logic               is_wr_q,     is_wr_d;
  logic               tmo_flag_q,  tmo_flag_d;
  logic [ADDR_W-1:0]  addr_q,      addr_d;
  logic [DATA_W-1:0]  wdata_q,     wdata_d;
  logic [DATA_W-1:0]  rdata_q,     rdata_d;
  logic               avm_read_q,  avm_read_d;
  logic               avm_write_q, avm_write_d;
  logic               if_rd_q,     if_rd_d;
  logic               of_wr_q,     of_wr_d;
  logic [CMD_W-1:0]   of_d_q,      of_d_d;
  logic               busy_q,      busy_d;
  logic [CMD_W-1:0]   rsp_c;
  logic               timer_last_c;
  logic               unused_if_d;

  // Only some command bits carry meaning; the rest are deliberately ignored
  assign unused_if_d = ^if_d;

  assign timer_last_c = (timer_q == TMR_LAST);

  // Response word assembly from the latched command and captured data
  always_comb begin
    rsp_c                         = '0;
    rsp_c[ADDR_W+DATA_W-1:DATA_W] = addr_q;
    rsp_c[DATA_W-1:0]             = rdata_q;
    rsp_c[CMD_W-2]                = is_wr_q;
    rsp_c[CMD_W-1]                = tmo_flag_q;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    tmo_cnt_d   = tmo_cnt_q;
    is_wr_d     = is_wr_q;
    tmo_flag_d  = tmo_flag_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    avm_read_d  = avm_read_q;
    avm_write_d = avm_write_q;
    if_rd_d     = 1'b0;
    of_wr_d     = 1'b0;
    of_d_d      = of_d_q;

    case (state_q)
      S_IDLE: begin
        if (!if_rdempty) begin
          is_wr_d     = if_d[CMD_W-1];
          addr_d      = if_d[ADDR_W+DATA_W-1:DATA_W];
          wdata_d     = if_d[DATA_W-1:0];
          rdata_d     = '0;
          tmo_flag_d  = 1'b0;
          avm_write_d = if_d[CMD_W-1];
          avm_read_d  = !if_d[CMD_W-1];
          if_rd_d     = 1'b1;
          timer_d     = '0;
          state_d     = S_CMD;
        end
      end

      S_CMD: begin
        if (!avm_waitrequest) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          if (is_wr_q) begin
            state_d = (WR_ACK != 0) ? S_RSP : S_IDLE;
          end else if (avm_readdatavalid) begin
            rdata_d = avm_readdata;
            state_d = S_RSP;
          end else begin
            timer_d = '0;
            state_d = S_WAIT_RD;
          end
        end else if (timer_last_c) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          tmo_flag_d  = 1'b1;
          if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          // A timed-out write only reports back when write acks are enabled
          state_d = (is_wr_q && (WR_ACK == 0)) ? S_IDLE : S_RSP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_WAIT_RD: begin
        if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          state_d = S_RSP;
        end else if (timer_last_c) begin
          tmo_flag_d = 1'b1;
          if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          state_d = S_RSP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_RSP: begin
        if (!of_wrfull) begin
          of_wr_d = 1'b1;
          of_d_d  = rsp_c;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort: everything back to reset values except the timeout tally
    if (soft_clr) begin
      state_d     = S_IDLE;
      timer_d     = '0;
      tmo_cnt_d   = tmo_cnt_q;
      is_wr_d     = 1'b0;
      tmo_flag_d  = 1'b0;
      addr_d      = '0;
      wdata_d     = '0;
      rdata_d     = '0;
      avm_read_d  = 1'b0;
      avm_write_d = 1'b0;
      if_rd_d     = 1'b0;
      of_wr_d     = 1'b0;
      of_d_d      = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      tmo_cnt_q   <= '0;
      is_wr_q     <= 1'b0;
      tmo_flag_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      avm_read_q  <= 1'b0;
      avm_write_q <= 1'b0;
      if_rd_q     <= 1'b0;
      of_wr_q     <= 1'b0;
      of_d_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      tmo_cnt_q   <= tmo_cnt_d;
      is_wr_q     <= is_wr_d;
      tmo_flag_q  <= tmo_flag_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      avm_read_q  <= avm_read_d;
      avm_write_q <= avm_write_d;
      if_rd_q     <= if_rd_d;
      of_wr_q     <= of_wr_d;
      of_d_q      <= of_d_d;
      busy_q      <= busy_d;
    end
  end

  assign if_rd         = if_rd_q;
  assign of_wr         = of_wr_q;
  assign of_d          = of_d_q;
  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign busy          = busy_q;
  assign tmo_cnt       = tmo_cnt_q;

endmodule

// File: tb/tb_lms_avmm_cmd_bridge.sv
// Directed bench for lms_avmm_cmd_bridge: dut0 has WR_ACK=0, dut1 has WR_ACK=1,
// both with TMO_CYC=8. Input FIFOs are queue models popped on if_rd; responses
// are collected from of_wr pulses.
module tb_lms_avmm_cmd_bridge;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 32;
  localparam int unsigned TMO = 8;

  logic clk;
  logic rst_n;
  logic soft_clr;

  logic [CW-1:0] if_d0, if_d1, of_d0, of_d1;
  logic          if_rdempty0, if_rdempty1, if_rd0, if_rd1;
  logic          of_wr0, of_wr1, of_wrfull0, of_wrfull1;
  logic [AW-1:0] addr0, addr1;
  logic          rd0, rd1, wr0, wr1;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
  logic          wreq0, wreq1, rdv0, rdv1;
  logic          busy0, busy1;
  logic [7:0]    tmo0, tmo1;

  logic [CW-1:0] q0[$], q1[$], rsp0[$], rsp1[$];
  int            bad_rd0 = 0;
  int            bad_rd1 = 0;
  int            n_chk   = 0;
  int            n_fail  = 0;

  lms_avmm_cmd_bridge #(.ADDR_W(AW), .DATA_W(DW), .CMD_W(CW), .TMO_CYC(TMO), .WR_ACK(0)) dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .soft_clr(soft_clr),
    .if_d(if_d0), .if_rdempty(if_rdempty0), .if_rd(if_rd0),
    .of_d(of_d0), .of_wr(of_wr0), .of_wrfull(of_wrfull0),
    .avm_address(addr0), .avm_read(rd0), .avm_write(wr0), .avm_writedata(wdata0),
    .avm_waitrequest(wreq0), .avm_readdata(rdata0), .avm_readdatavalid(rdv0),
    .busy(busy0), .tmo_cnt(tmo0)
  );

  lms_avmm_cmd_bridge #(.ADDR_W(AW), .DATA_W(DW), .CMD_W(CW), .TMO_CYC(TMO), .WR_ACK(1)) dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .soft_clr(soft_clr),
    .if_d(if_d1), .if_rdempty(if_rdempty1), .if_rd(if_rd1),
    .of_d(of_d1), .of_wr(of_wr1), .of_wrfull(of_wrfull1),
    .avm_address(addr1), .avm_read(rd1), .avm_write(wr1), .avm_writedata(wdata1),
    .avm_waitrequest(wreq1), .avm_readdata(rdata1), .avm_readdatavalid(rdv1),
    .busy(busy1), .tmo_cnt(tmo1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    if_rdempty0 = (q0.size() == 0);
    if_d0       = (q0.size() != 0) ? q0[0] : '0;
    if_rdempty1 = (q1.size() == 0);
    if_d1       = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // Advance one clock; FIFO pops and response captures use pre-edge values
  task automatic tick();
    logic r0, r1, w0, w1;
    logic [CW-1:0] d0, d1;
    r0 = if_rd0; r1 = if_rd1; w0 = of_wr0; w1 = of_wr1; d0 = of_d0; d1 = of_d1;
    @(posedge clk);
    #1;
    if (r0) begin
      if (q0.size() == 0) bad_rd0++;
      else void'(q0.pop_front());
    end
    if (r1) begin
      if (q1.size() == 0) bad_rd1++;
      else void'(q1.pop_front());
    end
    if (w0) rsp0.push_back(d0);
    if (w1) rsp1.push_back(d1);
    refresh();
  endtask

  task automatic push0(input logic [CW-1:0] c);
    q0.push_back(c);
    refresh();
  endtask

  task automatic push1(input logic [CW-1:0] c);
    q1.push_back(c);
    refresh();
  endtask

  initial begin
    int   n;
    logic seen;

    rst_n = 1'b0; soft_clr = 1'b0;
    of_wrfull0 = 1'b0; of_wrfull1 = 1'b0;
    wreq0 = 1'b0; wreq1 = 1'b0; rdv0 = 1'b0; rdv1 = 1'b0;
    rdata0 = '0; rdata1 = '0;
    refresh();

    // Reset state
    #20;
    check_eq("rst_read",  32'(rd0),    32'h0);
    check_eq("rst_write", 32'(wr0),    32'h0);
    check_eq("rst_if_rd", 32'(if_rd0), 32'h0);
    check_eq("rst_of_wr", 32'(of_wr0), 32'h0);
    check_eq("rst_of_d",  of_d0,       32'h0);
    check_eq("rst_busy",  32'(busy0),  32'h0);
    check_eq("rst_tmo",   32'(tmo0),   32'h0);
    #2 rst_n = 1'b1;
    tick();

    // 1: write, no waitrequest, no ack
    push0(32'h8000_125A);
    tick();
    check_eq("t1_write_on", 32'(wr0),    32'h1);
    check_eq("t1_addr",     32'(addr0),  32'h12);
    check_eq("t1_wdata",    32'(wdata0), 32'h5A);
    check_eq("t1_if_rd",    32'(if_rd0), 32'h1);
    check_eq("t1_busy_on",  32'(busy0),  32'h1);
    tick();
    check_eq("t1_write_off", 32'(wr0),   32'h0);
    check_eq("t1_busy_off",  32'(busy0), 32'h0);
    repeat (3) tick();
    check_eq("t1_no_rsp", 32'(rsp0.size()), 32'h0);

    // 2: read with 3 waitrequest cycles, data 2 cycles after accept
    wreq0 = 1'b1;
    push0(32'h0000_3400);
    tick();
    check_eq("t2_read_on", 32'(rd0),   32'h1);
    check_eq("t2_addr",    32'(addr0), 32'h34);
    seen = 1'b1;
    repeat (3) begin
      tick();
      if (!rd0 || addr0 != 8'h34) seen = 1'b0;
    end
    check_eq("t2_read_held", 32'(seen), 32'h1);
    wreq0 = 1'b0;
    tick();
    check_eq("t2_read_off", 32'(rd0), 32'h0);
    tick();
    rdv0 = 1'b1; rdata0 = 8'hC3;
    tick();
    rdv0 = 1'b0; rdata0 = 8'h00;
    check_eq("t2_no_wr_yet", 32'(of_wr0), 32'h0);
    tick();
    check_eq("t2_of_wr", 32'(of_wr0), 32'h1);
    check_eq("t2_of_d",  of_d0,       32'h0000_34C3);
    tick();
    check_eq("t2_of_wr_pulse", 32'(of_wr0), 32'h0);

    // 3: read data never arrives
    push0(32'h0000_3400);
    n = 0;
    do begin tick(); n++; end while (!of_wr0 && n < 40);
    check_eq("t3_latency", 32'(n),    32'd11);
    check_eq("t3_of_d",    of_d0,     32'h8000_3400);
    check_eq("t3_tmo_cnt", 32'(tmo0), 32'h1);
    rdv0 = 1'b1; rdata0 = 8'hEE;
    seen = 1'b0;
    repeat (3) begin tick(); seen = seen | of_wr0 | busy0; end
    rdv0 = 1'b0; rdata0 = 8'h00;
    check_eq("t3_late_rdv_ignored", 32'(seen), 32'h0);

    // 4: read done while output FIFO is full, second command queued behind it
    of_wrfull0 = 1'b1;
    push0(32'h0000_5600);
    push0(32'h0000_7700);
    tick();
    rdv0 = 1'b1; rdata0 = 8'h99;
    tick();
    rdv0 = 1'b0; rdata0 = 8'h00;
    seen = 1'b0;
    repeat (10) begin tick(); seen = seen | of_wr0 | if_rd0 | !busy0; end
    check_eq("t4_hold_while_full", 32'(seen),      32'h0);
    check_eq("t4_no_pop",          32'(q0.size()), 32'h1);
    of_wrfull0 = 1'b0;
    tick();
    check_eq("t4_of_wr", 32'(of_wr0), 32'h1);
    check_eq("t4_of_d",  of_d0,       32'h0000_5699);
    rdv0 = 1'b1; rdata0 = 8'h11;
    n = 0;
    do begin tick(); n++; end while (!of_wr0 && n < 40);
    rdv0 = 1'b0; rdata0 = 8'h00;
    check_eq("t4_second_lat", 32'(n), 32'd3);
    check_eq("t4_second_d",   of_d0,  32'h0000_7711);

    // Write stuck in waitrequest, no ack: strobe held exactly TMO cycles
    wreq0 = 1'b1;
    push0(32'h8000_0101);
    tick();
    n = 0;
    while (wr0 && n < 50) begin n++; tick(); end
    check_eq("tw_write_cycles", 32'(n),            32'd8);
    check_eq("tw_busy",         32'(busy0),        32'h0);
    check_eq("tw_tmo_cnt",      32'(tmo0),         32'h2);
    check_eq("tw_rsp_count",    32'(rsp0.size()),  32'd4);

    // 5: four back-to-back acked writes, then a timed-out acked write
    push1(32'h8000_A111);
    push1(32'h8000_B222);
    push1(32'h8000_C333);
    push1(32'h8000_D444);
    n = 0;
    while (rsp1.size() < 4 && n < 100) begin tick(); n++; end
    check_eq("t5_rsp_count", 32'(rsp1.size()), 32'd4);
    if (rsp1.size() >= 4) begin
      check_eq("t5_rsp0", rsp1[0], 32'h4000_A100);
      check_eq("t5_rsp1", rsp1[1], 32'h4000_B200);
      check_eq("t5_rsp2", rsp1[2], 32'h4000_C300);
      check_eq("t5_rsp3", rsp1[3], 32'h4000_D400);
    end
    wreq1 = 1'b1;
    push1(32'h8000_EE55);
    n = 0;
    do begin tick(); n++; end while (!of_wr1 && n < 40);
    check_eq("t5_tmo_lat", 32'(n),    32'd10);
    check_eq("t5_tmo_rsp", of_d1,     32'hC000_EE00);
    check_eq("t5_tmo_cnt", 32'(tmo1), 32'h1);
    wreq1 = 1'b0;
    tick();

    // 6a: soft_clr during a stalled read
    push0(32'h0000_4300);
    tick();
    tick();
    check_eq("t6s_read_on", 32'(rd0), 32'h1);
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    check_eq("t6s_read_off", 32'(rd0),   32'h0);
    check_eq("t6s_busy",     32'(busy0), 32'h0);
    check_eq("t6s_tmo_kept", 32'(tmo0),  32'h2);
    repeat (12) tick();
    check_eq("t6s_no_rsp", 32'(rsp0.size()), 32'd4);

    // 6b: async reset during a stalled read
    push0(32'h0000_4200);
    tick();
    tick();
    check_eq("t6r_read_on", 32'(rd0), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("t6r_read_off", 32'(rd0),   32'h0);
    check_eq("t6r_busy",     32'(busy0), 32'h0);
    check_eq("t6r_tmo_clr",  32'(tmo0),  32'h0);
    #1 rst_n = 1'b1;
    wreq0 = 1'b0;
    repeat (12) tick();
    check_eq("t6r_no_rsp", 32'(rsp0.size()), 32'd4);
    check_eq("t6r_idle",   32'(busy0),        32'h0);

    check_eq("rsp0_order0", rsp0[0], 32'h0000_34C3);
    check_eq("rsp0_order1", rsp0[1], 32'h8000_3400);
    check_eq("no_rd_empty0", 32'(bad_rd0), 32'h0);
    check_eq("no_rd_empty1", 32'(bad_rd1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
